hazard_scoreboard: RTL and testbench



---
 rtl/hazard_scoreboard.sv | 105 ++++++++++
 tb/tb_hazard_scoreboard.sv | 203 ++++++++++++++++++++
 2 files changed

// File: rtl/hazard_scoreboard.sv
// Register scoreboard tracking outstanding long-latency writes and stalling decode on hazards.
// Optional HAZARD_SCOREBOARD_WB_BYPASS_EN: same-cycle writeback relieves RAW and full stalls.
module hazard_scoreboard #(
  parameter int unsigned NUM_REGS        = 32,
  parameter int unsigned REG_W           = $clog2(NUM_REGS),
  parameter int unsigned MAX_OUTSTANDING = 4,
  parameter int unsigned CNT_W           = $clog2(MAX_OUTSTANDING + 1)
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [REG_W-1:0]    dec_rs1,
  input  logic [REG_W-1:0]    dec_rs2,
  input  logic                dec_use_rs1,
  input  logic                dec_use_rs2,
  input  logic [REG_W-1:0]    dec_rd,
  input  logic                dec_wr_rd,
  input  logic                dec_drain,
  input  logic                issue_valid,
  input  logic                issue_long,
  input  logic                wb_valid,
  input  logic [REG_W-1:0]    wb_rd,
  output logic                stall_issue,
  output logic [NUM_REGS-1:0] pending,
  output logic [CNT_W-1:0]    outstanding,
  output logic                full,
  output logic                err_spurious,
  output logic [31:0]         stall_cycles
);

  logic                raw;
  logic                waw;
  logic                full_stall;
  logic                drain_stall;
  logic                raw_rs1;
  logic                raw_rs2;
  logic                set;
  logic                clr;
  logic                spurious;
  logic                byp_rs1;
  logic                byp_rs2;
  logic                byp_full;
  logic [NUM_REGS-1:0] pending_next;
  logic [CNT_W-1:0]    outstanding_next;

  assign full = (outstanding == CNT_W'(MAX_OUTSTANDING));

  assign clr      = wb_valid && pending[wb_rd];
  assign spurious = wb_valid && !pending[wb_rd];

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
  // Operand matching this cycle's writeback arrives on the WB forward path.
  assign byp_rs1  = wb_valid && (wb_rd == dec_rs1);
  assign byp_rs2  = wb_valid && (wb_rd == dec_rs2);
  assign byp_full = clr;
`else
  assign byp_rs1  = 1'b0;
  assign byp_rs2  = 1'b0;
  assign byp_full = 1'b0;
`endif

  always_comb begin
    raw_rs1     = dec_use_rs1 && pending[dec_rs1] && !byp_rs1;
    raw_rs2     = dec_use_rs2 && pending[dec_rs2] && !byp_rs2;
    raw         = raw_rs1 || raw_rs2;
    waw         = dec_wr_rd && pending[dec_rd];
    full_stall  = issue_long && dec_wr_rd && full && !byp_full;
    drain_stall = dec_drain && (outstanding != '0);
    stall_issue = raw || waw || full_stall || drain_stall;
  end

  assign set = issue_valid && !stall_issue && issue_long && dec_wr_rd && (dec_rd != '0);

  // Set is applied after clear so a same-register collision leaves the bit high.
  always_comb begin
    pending_next = pending;
    if (clr) pending_next[wb_rd] = 1'b0;
    if (set) pending_next[dec_rd] = 1'b1;
    pending_next[0] = 1'b0;
  end

  always_comb begin
    outstanding_next = outstanding;
    unique case ({set, clr})
      2'b10:   outstanding_next = outstanding + CNT_W'(1);
      2'b01:   outstanding_next = outstanding - CNT_W'(1);
      default: outstanding_next = outstanding;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      pending      <= '0;
      outstanding  <= '0;
      err_spurious <= 1'b0;
      stall_cycles <= '0;
    end else begin
      pending      <= pending_next;
      outstanding  <= outstanding_next;
      err_spurious <= spurious;
      if (stall_issue && (stall_cycles != '1))
        stall_cycles <= stall_cycles + 32'd1;
    end
  end

endmodule

// File: tb/tb_hazard_scoreboard.sv
// Scoreboard bench for hazard_scoreboard: queue of expected per-cycle outputs from an array model.
module tb_hazard_scoreboard;
  localparam int NR  = 32;
  localparam int MAX = 4;

  logic        clk = 1'b0;
  logic        rst;
  logic [4:0]  dec_rs1, dec_rs2, dec_rd, wb_rd;
  logic        dec_use_rs1, dec_use_rs2, dec_wr_rd, dec_drain;
  logic        issue_valid, issue_long, wb_valid;
  logic        stall_issue, full, err_spurious;
  logic [31:0] pending, stall_cycles;
  logic [2:0]  outstanding;

  hazard_scoreboard #(.NUM_REGS(NR), .MAX_OUTSTANDING(MAX)) dut (
    .clk(clk), .rst(rst),
    .dec_rs1(dec_rs1), .dec_rs2(dec_rs2),
    .dec_use_rs1(dec_use_rs1), .dec_use_rs2(dec_use_rs2),
    .dec_rd(dec_rd), .dec_wr_rd(dec_wr_rd), .dec_drain(dec_drain),
    .issue_valid(issue_valid), .issue_long(issue_long),
    .wb_valid(wb_valid), .wb_rd(wb_rd),
    .stall_issue(stall_issue), .pending(pending), .outstanding(outstanding),
    .full(full), .err_spurious(err_spurious), .stall_cycles(stall_cycles)
  );

  always #5 clk = ~clk;

`ifdef HAZARD_SCOREBOARD_WB_BYPASS_EN
  localparam bit BYP = 1'b1;
`else
  localparam bit BYP = 1'b0;
`endif

  typedef struct {
    bit          stall;
    logic [31:0] pend;
    int unsigned cnt;
    bit          full;
    bit          err;
    int unsigned sc;
  } exp_t;

  exp_t q[$];
  int   tests = 0;
  int   fails = 0;

  // Reference model: set of pending registers, an in-flight tally, error flag, stall tally.
  bit          mp[NR];
  int          mcnt;
  bit          merr;
  int unsigned msc;

  task automatic check(input string name, input longint act, input longint exp);
    tests++;
    if (act != exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (q.size() > 0) begin
      exp_t e;
      e = q.pop_front();
      check("stall_issue", stall_issue, e.stall);
      check("pending", pending, e.pend);
      check("outstanding", outstanding, e.cnt);
      check("full", full, e.full);
      check("err_spurious", err_spurious, e.err);
      check("stall_cycles", stall_cycles, e.sc);
      check("outstanding_bound", outstanding <= MAX, 1);
    end
  end

  task automatic idle();
    rst = 0; dec_rs1 = 0; dec_rs2 = 0; dec_rd = 0; wb_rd = 0;
    dec_use_rs1 = 0; dec_use_rs2 = 0; dec_wr_rd = 0; dec_drain = 0;
    issue_valid = 0; issue_long = 0; wb_valid = 0;
  endtask

  task automatic issue_long_wr(input int r);
    issue_valid = 1; issue_long = 1; dec_wr_rd = 1; dec_rd = 5'(r);
  endtask

  // Predict this cycle's outputs from model state and inputs, queue them, then advance the model.
  task automatic step();
    exp_t e;
    bit raw, waw, clr, fst, dst, stl, set;
    bit nx[NR];
    raw = (dec_use_rs1 && mp[dec_rs1] && !(BYP && wb_valid && wb_rd == dec_rs1)) ||
          (dec_use_rs2 && mp[dec_rs2] && !(BYP && wb_valid && wb_rd == dec_rs2));
    waw = dec_wr_rd && mp[dec_rd];
    clr = wb_valid && mp[wb_rd];
    fst = issue_long && dec_wr_rd && (mcnt == MAX) && !(BYP && clr);
    dst = dec_drain && (mcnt != 0);
    stl = raw || waw || fst || dst;
    set = issue_valid && !stl && issue_long && dec_wr_rd && dec_rd != 0;
    e.stall = stl;
    for (int i = 0; i < NR; i++) e.pend[i] = mp[i];
    e.cnt = mcnt; e.full = (mcnt == MAX); e.err = merr; e.sc = msc;
    q.push_back(e);
    nx = mp;
    if (clr) nx[wb_rd] = 0;
    if (set) nx[dec_rd] = 1;
    if (set && !clr && mcnt == MAX) begin
      fails++; $display("FAIL counter_overflow: count %0d required below %0d", mcnt, MAX);
    end
    if (clr && !set && mcnt == 0) begin
      fails++; $display("FAIL counter_underflow: count %0d required above 0", mcnt);
    end
    @(posedge clk);
    #1;
    if (rst) begin
      foreach (mp[i]) mp[i] = 0;
      mcnt = 0; merr = 0; msc = 0;
    end else begin
      mp   = nx;
      mcnt = mcnt + int'(set) - int'(clr);
      merr = wb_valid && !mp_old_bit(e.pend, wb_rd);
      if (stl && msc != 32'hFFFF_FFFF) msc++;
    end
  endtask

  function automatic bit mp_old_bit(input logic [31:0] v, input logic [4:0] r);
    return v[r];
  endfunction

  function automatic int pick_pending();
    int c[$];
    for (int i = 1; i < NR; i++) if (mp[i]) c.push_back(i);
    if (c.size() == 0) return int'($urandom_range(0, 9));
    return c[$urandom_range(0, c.size() - 1)];
  endfunction

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    idle(); rst = 1;
    repeat (2) @(posedge clk);
    #1;
    foreach (mp[i]) mp[i] = 0;
    mcnt = 0; merr = 0; msc = 0;

    idle(); step();
    idle(); issue_long_wr(5); step();
    idle(); dec_use_rs1 = 1; dec_rs1 = 5; step(); step();
    idle(); dec_use_rs1 = 1; dec_rs1 = 5; wb_valid = 1; wb_rd = 5; step();
    idle(); dec_use_rs1 = 1; dec_rs1 = 5; step();

    for (int r = 1; r <= 4; r++) begin idle(); issue_long_wr(r); step(); end
    idle(); issue_long_wr(6); step();
    idle(); issue_long_wr(6); wb_valid = 1; wb_rd = 1; step();
    idle(); step();
    for (int r = 1; r < NR; r++) if (mp[r]) begin idle(); wb_valid = 1; wb_rd = 5'(r); step(); end

    idle(); issue_long_wr(7); step();
    idle(); dec_drain = 1; step(); step();
    idle(); dec_drain = 1; wb_valid = 1; wb_rd = 7; step();
    idle(); dec_drain = 1; step();

    idle(); wb_valid = 1; wb_rd = 9; step();
    idle(); step(); step();
    idle(); issue_long_wr(0); step();
    idle(); wb_valid = 1; wb_rd = 0; step();

    idle(); issue_long_wr(3); step();
    idle(); issue_long_wr(3); wb_valid = 1; wb_rd = 3; step();
    idle(); issue_long_wr(4); wb_valid = 1; wb_rd = 3; step();
    idle(); step();

    idle(); issue_long_wr(2); step();
    idle(); issue_long_wr(8); dec_use_rs1 = 1; dec_rs1 = 2; rst = 1; step();
    idle(); step();

    for (int n = 0; n < 2000; n++) begin
      idle();
      rst         = ($urandom_range(0, 63) == 0);
      dec_rs1     = 5'($urandom_range(0, 9));
      dec_rs2     = 5'($urandom_range(0, 9));
      dec_rd      = 5'($urandom_range(0, 9));
      dec_use_rs1 = 1'($urandom);
      dec_use_rs2 = 1'($urandom);
      dec_wr_rd   = ($urandom_range(0, 3) != 0);
      dec_drain   = ($urandom_range(0, 9) == 0);
      issue_valid = ($urandom_range(0, 3) != 0);
      issue_long  = 1'($urandom);
      wb_valid    = ($urandom_range(0, 2) == 0);
      wb_rd       = ($urandom_range(0, 4) != 0) ? 5'(pick_pending()) : 5'($urandom_range(0, 9));
      step();
    end

    idle();
    @(negedge clk);
    #1;
    check("queue_drained", q.size(), 0);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
